// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester burst arbiter.
package mux_arb_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/mux_arb_2to1_if.sv
// Handshake bundle between the two requesters, the arbiter and the downstream port.
interface mux_arb_2to1_if
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_last;
  logic             in0_ready;

  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             in1_ready;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_src;
  logic             out_ready;

  logic             busy;

  modport slave (
    input  in0_valid, in0_data, in0_last,
    input  in1_valid, in1_data, in1_last,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_data, out_last, out_src,
    output busy
  );

  modport master (
    output in0_valid, in0_data, in0_last,
    output in1_valid, in1_data, in1_last,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_data, out_last, out_src,
    input  busy
  );

endinterface

// File: rtl/arb_pick.sv
// Winner selection for the burst arbiter.
// MUX_ARB_RR_EN selects round-robin tie breaking; otherwise requester 0 wins ties.
module arb_pick
  import mux_arb_pkg::*;
(
  input  logic   valid0,
  input  logic   valid1,
  input  state_e state,
  input  logic   owner,
  input  logic   last_owner,
  output logic   winner
);

  logic tie_pick_s;

`ifdef MUX_ARB_RR_EN
  assign tie_pick_s = ~last_owner;
`else
  logic unused_last_owner_s;
  assign unused_last_owner_s = last_owner;
  assign tie_pick_s          = REQ0;
`endif

  // owner keeps the grant mid-burst; otherwise a lone requester or the tie rule wins
  always_comb begin
    winner = REQ0;
    case (state)
      ST_LOCK: winner = owner;
      ST_IDLE: begin
        if (valid0 && !valid1) begin
          winner = REQ0;
        end else if (valid1 && !valid0) begin
          winner = REQ1;
        end else begin
          winner = tie_pick_s;
        end
      end
      default: winner = REQ0;
    endcase
  end

endmodule

// File: rtl/mux_arb_chk.sv
// Requester protocol checker, built only with MUX_ARB_ASSERT_EN defined:
// a pending beat must stay valid with stable data/last until accepted.
`ifdef MUX_ARB_ASSERT_EN
module mux_arb_chk #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  input logic             valid,
  input logic             ready,
  input logic             last,
  input logic [WIDTH-1:0] data
);

  property p_hold_pending;
    @(posedge clk) disable iff (!rst_n)
      (valid && !ready) |=> (valid && $stable(data) && $stable(last));
  endproperty

  a_hold_pending: assert property (p_hold_pending)
    else $error("requester changed a pending beat");

endmodule
`endif

// File: rtl/mux_arb_2to1.sv
// Two-requester burst arbiter driving one registered output slot.
// Optional: MUX_ARB_RR_EN (round-robin ties, in arb_pick), MUX_ARB_ASSERT_EN (protocol checkers).
module mux_arb_2to1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  mux_arb_2to1_if.slave bus
);

  state_e           state_r;
  logic             owner_r;
  logic             last_owner_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_last_r;
  logic             out_src_r;

  logic             winner_s;
  logic             slot_free_s;
  logic             win_valid_s;
  logic [WIDTH-1:0] win_data_s;
  logic             win_last_s;
  logic             accept_s;
  logic             rdy0_s;
  logic             rdy1_s;

  arb_pick u_pick (
    .valid0     (bus.in0_valid),
    .valid1     (bus.in1_valid),
    .state      (state_r),
    .owner      (owner_r),
    .last_owner (last_owner_r),
    .winner     (winner_s)
  );

  // 2:1 datapath mux on the winner plus the ready/accept handshake
  always_comb begin
    slot_free_s = !out_valid_r || bus.out_ready;
    if (winner_s == REQ1) begin
      win_valid_s = bus.in1_valid;
      win_data_s  = bus.in1_data;
      win_last_s  = bus.in1_last;
    end else begin
      win_valid_s = bus.in0_valid;
      win_data_s  = bus.in0_data;
      win_last_s  = bus.in0_last;
    end
    accept_s = win_valid_s && slot_free_s && rst_n;
    if (!rst_n) begin
      rdy0_s = 1'b0;
      rdy1_s = 1'b0;
    end else begin
      rdy0_s = slot_free_s && (winner_s == REQ0);
      rdy1_s = slot_free_s && (winner_s == REQ1);
    end
  end

  // output slot, burst lock state and tie history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= REQ0;
      last_owner_r <= REQ1;
      out_valid_r  <= 1'b0;
      out_data_r   <= {WIDTH{1'b0}};
      out_last_r   <= 1'b0;
      out_src_r    <= REQ0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= win_data_s;
      out_last_r  <= win_last_s;
      out_src_r   <= winner_s;
      if (win_last_s) begin
        last_owner_r <= winner_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (!win_last_s) begin
            state_r <= ST_LOCK;
            owner_r <= winner_s;
          end
        end
        ST_LOCK: begin
          if (win_last_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in0_ready = rdy0_s;
  assign bus.in1_ready = rdy1_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_src   = out_src_r;
  assign bus.busy      = (state_r == ST_LOCK);

`ifdef MUX_ARB_ASSERT_EN
  mux_arb_chk #(.WIDTH(WIDTH)) u_chk0 (
    .clk(clk), .rst_n(rst_n), .valid(bus.in0_valid), .ready(bus.in0_ready),
    .last(bus.in0_last), .data(bus.in0_data)
  );
  mux_arb_chk #(.WIDTH(WIDTH)) u_chk1 (
    .clk(clk), .rst_n(rst_n), .valid(bus.in1_valid), .ready(bus.in1_ready),
    .last(bus.in1_last), .data(bus.in1_data)
  );
`endif

endmodule

// File: tb/tb_mux_arb_2to1.sv
// Bench for mux_arb_2to1: transaction-level model, directed scenarios, random bursts.
module tb_mux_arb_2to1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mux_arb_2to1_if #(.WIDTH(32)) bus();

  mux_arb_2to1 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus per requester
  logic        v   [2];
  logic [31:0] d   [2];
  logic        l   [2];
  logic        acc [2];
  int          rem [2];
  logic        ordy;

  // model: slot contents, current burst owner (-1 = none), last burst finisher
  logic        m_ovalid;
  logic [31:0] m_odata;
  logic        m_olast;
  logic        m_osrc;
  logic        m_lastown;
  int          m_owner;

  logic        exp_src [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ovalid  = 1'b0;
    m_odata   = 32'h0;
    m_olast   = 1'b0;
    m_osrc    = 1'b0;
    m_lastown = 1'b1;
    m_owner   = -1;
  endtask

  function automatic int m_winner();
    if (m_owner >= 0) return m_owner;
    if (v[0] && !v[1]) return 0;
    if (v[1] && !v[0]) return 1;
    if (v[0] && v[1]) begin
`ifdef MUX_ARB_RR_EN
      return m_lastown ? 0 : 1;
`else
      return 0;
`endif
    end
    return -1;
  endfunction

  task automatic drive();
    bus.in0_valid = v[0];
    bus.in0_data  = d[0];
    bus.in0_last  = l[0];
    bus.in1_valid = v[1];
    bus.in1_data  = d[1];
    bus.in1_last  = l[1];
    bus.out_ready = ordy;
  endtask

  // one clock: check registered outputs, apply inputs, check readies, advance model
  task automatic cycle();
    int   w;
    logic sf;
    @(negedge clk);
    chk("out_valid", bus.out_valid, m_ovalid);
    chk("out_data", bus.out_data, m_odata);
    chk("out_last", bus.out_last, m_olast);
    chk("out_src", bus.out_src, m_osrc);
    chk("busy", bus.busy, (m_owner >= 0));
    drive();
    #1;
    w  = m_winner();
    sf = !m_ovalid || ordy;
    if (w >= 0) begin
      chk("in0_ready", bus.in0_ready, (w == 0) && sf);
      chk("in1_ready", bus.in1_ready, (w == 1) && sf);
    end
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    if (w >= 0 && v[w] && sf) begin
      acc[w]   = 1'b1;
      m_ovalid = 1'b1;
      m_odata  = d[w];
      m_olast  = l[w];
      m_osrc   = w[0];
      if (l[w]) begin
        m_owner   = -1;
        m_lastown = w[0];
      end else begin
        m_owner = w;
      end
    end else if (ordy) begin
      m_ovalid = 1'b0;
    end
  endtask

  // reset pulse with current inputs still applied, then clear requesters and release
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", bus.out_valid, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_in0_ready", bus.in0_ready, 32'd0);
    chk("rst_in1_ready", bus.in1_ready, 32'd0);
    @(negedge clk);
    v[0] = 1'b0; v[1] = 1'b0; rem[0] = 0; rem[1] = 0;
    drive();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      v[r] = 1'b0; d[r] = 32'h0; l[r] = 1'b0; rem[r] = 0; acc[r] = 1'b0;
    end
    ordy = 1'b1;
    drive();
    model_reset();
`ifdef MUX_ARB_RR_EN
    exp_src[0] = 1'b0; exp_src[1] = 1'b1; exp_src[2] = 1'b0; exp_src[3] = 1'b1;
`else
    exp_src[0] = 1'b0; exp_src[1] = 1'b0; exp_src[2] = 1'b0; exp_src[3] = 1'b0;
`endif
    #3;
    chk("init_out_valid", bus.out_valid, 32'd0);
    chk("init_out_data", bus.out_data, 32'd0);
    chk("init_out_src", bus.out_src, 32'd0);
    chk("init_busy", bus.busy, 32'd0);
    chk("init_in0_ready", bus.in0_ready, 32'd0);
    chk("init_in1_ready", bus.in1_ready, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single beat
    v[0] = 1'b1; d[0] = 32'hDEADBEEF; l[0] = 1'b1;
    cycle();
    chk("single_in0_ready", bus.in0_ready, 32'd1);
    v[0] = 1'b0;
    cycle();
    chk("single_valid", bus.out_valid, 32'd1);
    chk("single_data", bus.out_data, 32'hDEADBEEF);
    chk("single_src", bus.out_src, 32'd0);
    chk("single_busy", bus.busy, 32'd0);

    // empty
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i == 0) chk("empty_fall", bus.out_valid, 32'd0);
    end
    chk("empty_valid", bus.out_valid, 32'd0);
    chk("empty_busy", bus.busy, 32'd0);

    // tie after reset
    do_reset();
    v[0] = 1'b1; d[0] = 32'h11111111; l[0] = 1'b1;
    v[1] = 1'b1; d[1] = 32'h22222222; l[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i > 0) chk("tie_src", bus.out_src, exp_src[i-1]);
    end
    v[0] = 1'b0; v[1] = 1'b0;
    cycle();
    chk("tie_src_last", bus.out_src, exp_src[3]);

    // burst lock: in1 four beats, in0 waiting from beat 2 on
    v[1] = 1'b1; d[1] = 32'h000000B0; l[1] = 1'b0;
    cycle();
    v[0] = 1'b1; d[0] = 32'h000000A0; l[0] = 1'b1;
    for (int k = 1; k < 4; k++) begin
      d[1] = 32'h000000B0 + k;
      l[1] = (k == 3);
      cycle();
      chk("lock_busy", bus.busy, 32'd1);
      chk("lock_in0_blocked", bus.in0_ready, 32'd0);
    end
    v[1] = 1'b0;
    cycle();
    chk("lock_release_rdy", bus.in0_ready, 32'd1);
    chk("lock_last_src", bus.out_src, 32'd1);
    chk("lock_last_data", bus.out_data, 32'h000000B3);
    chk("lock_busy_done", bus.busy, 32'd0);
    v[0] = 1'b0;
    cycle();
    chk("lock_follow_src", bus.out_src, 32'd0);
    chk("lock_follow_data", bus.out_data, 32'h000000A0);

    // back-pressure
    v[0] = 1'b1; d[0] = 32'h000000C0; l[0] = 1'b1; ordy = 1'b1;
    cycle();
    d[0] = 32'h000000C1; ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_rdy0", bus.in0_ready, 32'd0);
      chk("bp_hold", bus.out_data, 32'h000000C0);
      chk("bp_valid", bus.out_valid, 32'd1);
    end
    ordy = 1'b1;
    cycle();
    chk("bp_resume_rdy", bus.in0_ready, 32'd1);
    v[0] = 1'b0;
    cycle();
    chk("bp_next_valid", bus.out_valid, 32'd1);
    chk("bp_next_data", bus.out_data, 32'h000000C1);

    // reset mid-burst, then the other requester
    v[0] = 1'b1; d[0] = 32'h000000E0; l[0] = 1'b0;
    cycle();
    d[0] = 32'h000000E1;
    cycle();
    d[0] = 32'h000000E2;
    do_reset();
    v[1] = 1'b1; d[1] = 32'h000000F0; l[1] = 1'b1;
    cycle();
    chk("post_rst_in1_ready", bus.in1_ready, 32'd1);
    v[1] = 1'b0;
    cycle();
    chk("post_rst_src", bus.out_src, 32'd1);
    chk("post_rst_data", bus.out_data, 32'h000000F0);
    cycle();
    chk("post_rst_drain", bus.out_valid, 32'd0);

    // random bursts with random downstream stalls
    for (int c = 0; c < 3000; c++) begin
      ordy = ($urandom_range(0, 3) != 0);
      cycle();
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) begin
          rem[r]--;
          v[r] = 1'b0;
        end
        if (!v[r]) begin
          if (rem[r] == 0 && $urandom_range(0, 2) == 0) rem[r] = $urandom_range(1, 4);
          if (rem[r] > 0 && $urandom_range(0, 3) != 0) begin
            v[r] = 1'b1;
            d[r] = $urandom;
            l[r] = (rem[r] == 1);
          end
        end
      end
    end
    v[0] = 1'b0; v[1] = 1'b0; ordy = 1'b1;
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
